// File: rtl/inv_subbytes_seq.sv
// Inverse SubBytes engine: applies the AES inverse S-box to a 128-bit state, BYTES_PER_CYCLE bytes per clock.
// Defining INV_SUBBYTES_SELFCHECK_EN adds a forward-S-box recheck of every substituted byte, reported on err.
module inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err
);
    localparam int         B        = BYTES_PER_CYCLE;
    localparam int         SW       = 8 * B;
    localparam logic [3:0] IDX_STEP = 4'(B);
    localparam logic [3:0] IDX_LAST = 4'(16 - B);

    generate
        if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
            $error("inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(inv_affine(x));
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [127:0]  work;
    logic [3:0]    idx;
    logic [SW-1:0] run_bytes;
    logic [SW-1:0] sub_bytes;
    logic          last_step;

    // The bytes being substituted always sit at the top of work; the register rotates
    // left by one slice per RUN cycle and is back in original order after the last one.
    assign run_bytes = work[127 -: SW];
    assign last_step = (idx == IDX_LAST);

    always_comb begin
        sub_bytes = '0;
        for (int j = 0; j < B; j++) begin
            sub_bytes[8*j +: 8] = inv_sbox(run_bytes[8*j +: 8]);
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) state_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            work  <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        idx  <= '0;
                    end
                end
                S_RUN: begin
                    work <= (work << SW) | 128'(sub_bytes);
                    if (!last_step) idx <= idx + IDX_STEP;
                end
                default: ;
            endcase
        end
    end

    assign out_data = work;

`ifdef INV_SUBBYTES_SELFCHECK_EN
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ 8'h63;
    endfunction

    logic err_q;
    logic mismatch;

    always_comb begin
        mismatch = 1'b0;
        for (int j = 0; j < B; j++) begin
            if (fwd_affine(gf_inv(sub_bytes[8*j +: 8])) != run_bytes[8*j +: 8]) mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_RUN && mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
